// File: rtl/vbuf_arbiter.sv
// Round-robin burst arbiter between the scanout reader (m0) and the capture writer (m1) on the video-buffer DDR port.
// Bursts are locked once granted. One IDLE arbitration cycle separates bursts. Urgent reads may win at most URG_MAX times in a row over a waiting writer.
module vbuf_arbiter #(
    parameter int AW      = 28,
    parameter int DW      = 128,
    parameter int BW      = 8,
    parameter int URG_MAX = 4
) (
    input  logic            clk_vbuf,
    input  logic            reset_n,
    input  logic [AW-1:0]   m0_address,
    input  logic [BW-1:0]   m0_burstcount,
    input  logic            m0_read,
    output logic            m0_waitrequest,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_readdatavalid,
    input  logic            m0_urgent,
    input  logic [AW-1:0]   m1_address,
    input  logic [BW-1:0]   m1_burstcount,
    input  logic            m1_write,
    input  logic [DW-1:0]   m1_writedata,
    input  logic [DW/8-1:0] m1_byteenable,
    output logic            m1_waitrequest,
    output logic [AW-1:0]   mem_address,
    output logic [BW-1:0]   mem_burstcount,
    output logic            mem_read,
    output logic            mem_write,
    output logic [DW-1:0]   mem_writedata,
    output logic [DW/8-1:0] mem_byteenable,
    input  logic            mem_waitrequest,
    input  logic [DW-1:0]   mem_readdata,
    input  logic            mem_readdatavalid,
    output logic [1:0]      grant
);
    localparam int UW = $clog2(URG_MAX + 1);
    localparam logic [BW-1:0] CNT_ONE = BW'(1);

    typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_DATA} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          last_wr_q, last_wr_d;
    logic [UW-1:0] urg_q, urg_d;
    logic [1:0]    grant_q, grant_d;
    logic [BW-1:0] rem;
    logic          rd_acc, wr_acc, rd_beat;

    assign rd_acc  = (state_q == RD_CMD)  && m0_read  && !mem_waitrequest;
    assign wr_acc  = (state_q == WR_DATA) && m1_write && !mem_waitrequest;
    assign rd_beat = (state_q == RD_DATA) && mem_readdatavalid;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        urg_d     = urg_q;
        rem       = '0;
        case (state_q)
            IDLE: begin
                if (m0_read && m1_write) begin
                    if (m0_urgent && (int'(urg_q) < URG_MAX)) begin
                        state_d   = RD_CMD;
                        last_wr_d = 1'b0;
                        urg_d     = urg_q + 1'b1;
                    end else if (last_wr_q) begin
                        state_d   = RD_CMD;
                        last_wr_d = 1'b0;
                    end else begin
                        state_d   = WR_DATA;
                        last_wr_d = 1'b1;
                        urg_d     = '0;
                    end
                end else if (m0_read) begin
                    state_d   = RD_CMD;
                    last_wr_d = 1'b0;
                    urg_d     = '0;
                end else if (m1_write) begin
                    state_d   = WR_DATA;
                    last_wr_d = 1'b1;
                    urg_d     = '0;
                end
            end
            RD_CMD: begin
                if (rd_acc) begin
                    cnt_d   = (m0_burstcount == '0) ? CNT_ONE : m0_burstcount;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rd_beat) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = IDLE;
                end
            end
            WR_DATA: begin
                // A zero counter marks the first beat of the burst: load the length then.
                if (wr_acc) begin
                    rem = ((cnt_q == '0) ? ((m1_burstcount == '0) ? CNT_ONE : m1_burstcount)
                                         : cnt_q) - CNT_ONE;
                    cnt_d = rem;
                    if (rem == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        grant_d = 2'b00;
        case (state_d)
            RD_CMD, RD_DATA: grant_d = 2'b01;
            WR_DATA:         grant_d = 2'b10;
            default:         grant_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk_vbuf or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_wr_q <= 1'b1;
            urg_q     <= '0;
            grant_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
            urg_q     <= urg_d;
            grant_q   <= grant_d;
        end
    end

    assign grant            = grant_q;
    assign m0_waitrequest   = (state_q == RD_CMD)  ? mem_waitrequest : 1'b1;
    assign m1_waitrequest   = (state_q == WR_DATA) ? mem_waitrequest : 1'b1;
    assign m0_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_beat;
    assign mem_read         = (state_q == RD_CMD)  && m0_read;
    assign mem_write        = (state_q == WR_DATA) && m1_write;
    assign mem_address      = (state_q == WR_DATA) ? m1_address :
                              (state_q == RD_CMD)  ? m0_address : '0;
    assign mem_burstcount   = (state_q == WR_DATA) ? m1_burstcount :
                              (state_q == RD_CMD)  ? m0_burstcount : '0;
    assign mem_writedata    = (state_q == WR_DATA) ? m1_writedata  : '0;
    assign mem_byteenable   = (state_q == WR_DATA) ? m1_byteenable : '0;
endmodule

// File: tb/tb_vbuf_arbiter.sv
// Scoreboard bench for vbuf_arbiter: read/write bursts, contention order, urgency bound, stray data, mid-burst reset.
module tb_vbuf_arbiter;
    localparam int AW = 28, DW = 128, BW = 8, URG_MAX = 4;

    logic            clk_vbuf = 1'b0;
    logic            reset_n;
    logic [AW-1:0]   m0_address, m1_address, mem_address;
    logic [BW-1:0]   m0_burstcount, m1_burstcount, mem_burstcount;
    logic            m0_read, m0_waitrequest, m0_readdatavalid, m0_urgent;
    logic [DW-1:0]   m0_readdata, m1_writedata, mem_writedata, mem_readdata;
    logic            m1_write, m1_waitrequest;
    logic [DW/8-1:0] m1_byteenable, mem_byteenable;
    logic            mem_read, mem_write, mem_waitrequest, mem_readdatavalid;
    logic [1:0]      grant;

    int              n_chk = 0;
    int              n_pass = 0;
    int              rd_pend = 0;
    logic [DW-1:0]   dq[$];
    logic [1:0]      gq[$];

    always #5 clk_vbuf = ~clk_vbuf;

    vbuf_arbiter #(.AW(AW), .DW(DW), .BW(BW), .URG_MAX(URG_MAX)) dut (
        .clk_vbuf(clk_vbuf), .reset_n(reset_n),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_urgent(m0_urgent),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest),
        .mem_address(mem_address), .mem_burstcount(mem_burstcount), .mem_read(mem_read),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .grant(grant)
    );

    task automatic step();
        @(posedge clk_vbuf);
        #1;
    endtask

    task automatic idle_inputs();
        m0_address = '0; m0_burstcount = '0; m0_read = 1'b0; m0_urgent = 1'b0;
        m1_address = '0; m1_burstcount = '0; m1_write = 1'b0;
        m1_writedata = '0; m1_byteenable = '0;
        mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rd_pend = 0;
        reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    // Memory-side read responder used during arbitration runs: two beats per accepted read command.
    task automatic arb_drive();
        mem_readdatavalid = (rd_pend > 0);
        mem_readdata = {4{$urandom()}};
    endtask

    task automatic arb_advance();
        if (mem_readdatavalid && rd_pend > 0) rd_pend--;
        if (mem_read && !mem_waitrequest) rd_pend = 2;
    endtask

    task automatic test_reset();
        idle_inputs();
        mem_waitrequest = 1'b0;
        reset_n = 1'b0;
        #3;
        n_chk++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) $display("FAIL reset_waitreq got %b exp 11", {m0_waitrequest, m1_waitrequest}); else n_pass++;
        n_chk++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_mem_cmd got %b exp 00", {mem_read, mem_write}); else n_pass++;
        n_chk++; if (grant !== 2'b00) $display("FAIL reset_grant got %b exp 00", grant); else n_pass++;
        n_chk++; if (m0_readdatavalid !== 1'b0) $display("FAIL reset_rdv got %b exp 0", m0_readdatavalid); else n_pass++;
        step(); step();
        reset_n = 1'b1;
        step();
        n_chk++; if (grant !== 2'b00) $display("FAIL idle_no_req_grant got %b exp 00", grant); else n_pass++;
    endtask

    task automatic test_read_only();
        int beats = 0, drv = 0, bad_g = 0, bad_w = 0;
        logic [DW-1:0] exp;
        dq.delete();
        mem_waitrequest = 1'b1;
        m0_address = 28'h2000000; m0_burstcount = 8'd64; m0_read = 1'b1;
        step();
        n_chk++; if (grant !== 2'b01) $display("FAIL rd_grant got %b exp 01", grant); else n_pass++;
        n_chk++; if (mem_read !== 1'b1 || mem_address !== 28'h2000000 || mem_burstcount !== 8'd64)
            $display("FAIL rd_cmd got rd=%b addr=%h bc=%0d exp rd=1 addr=2000000 bc=64", mem_read, mem_address, mem_burstcount); else n_pass++;
        n_chk++; if (m0_waitrequest !== 1'b1) $display("FAIL rd_wait_stall got %b exp 1", m0_waitrequest); else n_pass++;
        step(); step();
        mem_waitrequest = 1'b0;
        #1;
        n_chk++; if (m0_waitrequest !== 1'b0) $display("FAIL rd_wait_pass got %b exp 0", m0_waitrequest); else n_pass++;
        step();
        m0_read = 1'b0;
        for (int cyc = 0; cyc < 400 && drv < 64; cyc++) begin
            mem_readdatavalid = ($urandom_range(0, 3) != 0);
            mem_readdata = {4{$urandom()}};
            if (mem_readdatavalid) begin dq.push_back(mem_readdata); drv++; end
            #1;
            if (grant !== 2'b01) bad_g++;
            if (m1_waitrequest !== 1'b1 || mem_read !== 1'b0) bad_w++;
            if (m0_readdatavalid) begin
                beats++;
                exp = (dq.size() > 0) ? dq.pop_front() : '0;
                n_chk++; if (m0_readdata !== exp) $display("FAIL rd_data beat %0d got %h exp %h", beats, m0_readdata, exp); else n_pass++;
            end
            step();
        end
        n_chk++; if (beats !== 64) $display("FAIL rd_beat_count got %0d exp 64", beats); else n_pass++;
        n_chk++; if (bad_g !== 0) $display("FAIL rd_grant_hold got %0d bad cycles exp 0", bad_g); else n_pass++;
        n_chk++; if (bad_w !== 0) $display("FAIL rd_m1_stall got %0d bad cycles exp 0", bad_w); else n_pass++;
        mem_readdatavalid = 1'b1;
        #1;
        n_chk++; if (grant !== 2'b00 || m0_readdatavalid !== 1'b0) $display("FAIL rd_end_idle got grant=%b rdv=%b exp 00/0", grant, m0_readdatavalid); else n_pass++;
        mem_readdatavalid = 1'b0;
        step();
    endtask

    task automatic test_write_only();
        int acc = 0, bad_r = 0, bad_w = 0;
        logic wt = 1'b0, took;
        logic [DW-1:0] exp;
        dq.delete();
        m1_address = 28'h0100000; m1_burstcount = 8'd16; m1_byteenable = '1;
        m1_writedata = {4{$urandom()}}; dq.push_back(m1_writedata);
        m1_write = 1'b1;
        mem_waitrequest = 1'b0;
        step();
        n_chk++; if (grant !== 2'b10) $display("FAIL wr_grant got %b exp 10", grant); else n_pass++;
        for (int cyc = 0; cyc < 100 && acc < 16; cyc++) begin
            mem_waitrequest = wt; wt = ~wt;
            #1;
            if (m0_readdatavalid !== 1'b0) bad_r++;
            if (m1_waitrequest !== mem_waitrequest || m0_waitrequest !== 1'b1) bad_w++;
            took = mem_write && !mem_waitrequest;
            if (took) begin
                acc++;
                exp = (dq.size() > 0) ? dq.pop_front() : '0;
                n_chk++; if (mem_writedata !== exp) $display("FAIL wr_data beat %0d got %h exp %h", acc, mem_writedata, exp); else n_pass++;
            end
            step();
            if (took) begin
                if (acc < 16) begin m1_writedata = {4{$urandom()}}; dq.push_back(m1_writedata); end
                else m1_write = 1'b0;
            end
        end
        n_chk++; if (acc !== 16) $display("FAIL wr_beat_count got %0d exp 16", acc); else n_pass++;
        n_chk++; if (grant !== 2'b00) $display("FAIL wr_end_idle got %b exp 00", grant); else n_pass++;
        n_chk++; if (bad_r !== 0 || bad_w !== 0) $display("FAIL wr_side_signals got rdv=%0d wait=%0d bad exp 0", bad_r, bad_w); else n_pass++;
        mem_waitrequest = 1'b0;
    endtask

    task automatic test_stray_data();
        int pulses = 0;
        mem_readdatavalid = 1'b1;
        for (int i = 0; i < 3; i++) begin #1; if (m0_readdatavalid) pulses++; step(); end
        m1_burstcount = 8'd4; m1_writedata = {4{$urandom()}}; m1_write = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin #1; if (m0_readdatavalid) pulses++; step(); end
        m1_write = 1'b0;
        #1;
        n_chk++; if (pulses !== 0) $display("FAIL stray_forwarded got %0d pulses exp 0", pulses); else n_pass++;
        n_chk++; if (grant !== 2'b00) $display("FAIL stray_wr_len got grant %b exp 00", grant); else n_pass++;
        mem_readdatavalid = 1'b0;
        m0_burstcount = 8'd4; m0_read = 1'b1;
        step(); step();
        m0_read = 1'b0;
        mem_readdatavalid = 1'b1;
        for (int i = 0; i < 4; i++) begin #1; if (m0_readdatavalid) pulses++; step(); end
        n_chk++; if (pulses !== 4 || grant !== 2'b00) $display("FAIL stray_rd_len got pulses=%0d grant=%b exp 4/00", pulses, grant); else n_pass++;
        mem_readdatavalid = 1'b0;
        step();
    endtask

    task automatic test_contention();
        int got = 0, idle_run = 0;
        logic [1:0] prev = 2'b00, exp;
        do_reset();
        gq.delete();
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01);
        gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10);
        m0_burstcount = 8'd2; m1_burstcount = 8'd2; m0_read = 1'b1; m1_write = 1'b1; m0_urgent = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            arb_drive();
            #1;
            if (grant !== 2'b00 && prev === 2'b00) begin
                got++;
                exp = (gq.size() > 0) ? gq.pop_front() : 2'b11;
                n_chk++; if (grant !== exp) $display("FAIL contention_order grant %0d got %b exp %b", got, grant, exp); else n_pass++;
                if (got > 1) begin
                    n_chk++; if (idle_run !== 1) $display("FAIL contention_gap got %0d idle cycles exp 1", idle_run); else n_pass++;
                end
                idle_run = 0;
            end else if (grant === 2'b00) idle_run++;
            arb_advance();
            prev = grant;
            step();
        end
        n_chk++; if (got !== 6) $display("FAIL contention_count got %0d grants exp 6", got); else n_pass++;
    endtask

    task automatic test_urgency();
        int got = 0;
        logic [1:0] prev = 2'b00, exp;
        do_reset();
        gq.delete();
        gq.push_back(2'b01); gq.push_back(2'b01); gq.push_back(2'b01);
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01);
        m0_burstcount = 8'd2; m1_burstcount = 8'd2; m0_read = 1'b1; m1_write = 1'b1; m0_urgent = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            arb_drive();
            #1;
            if (grant !== 2'b00 && prev === 2'b00) begin
                got++;
                exp = (gq.size() > 0) ? gq.pop_front() : 2'b11;
                n_chk++; if (grant !== exp) $display("FAIL urgency_order grant %0d got %b exp %b", got, grant, exp); else n_pass++;
            end
            arb_advance();
            prev = grant;
            step();
        end
        n_chk++; if (got !== 6) $display("FAIL urgency_count got %0d grants exp 6", got); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        int pulses = 0;
        do_reset();
        m0_address = 28'h2000000; m0_burstcount = 8'd64; m0_read = 1'b1;
        step(); step();
        m0_read = 1'b0;
        mem_readdatavalid = 1'b1;
        for (int i = 0; i < 10; i++) begin #1; if (m0_readdatavalid) pulses++; step(); end
        #1;
        n_chk++; if (pulses !== 10 || grant !== 2'b01) $display("FAIL mid_pre got pulses=%0d grant=%b exp 10/01", pulses, grant); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_chk++; if (grant !== 2'b00 || {m0_waitrequest, m1_waitrequest} !== 2'b11)
            $display("FAIL mid_reset got grant=%b wait=%b exp 00/11", grant, {m0_waitrequest, m1_waitrequest}); else n_pass++;
        n_chk++; if (m0_readdatavalid !== 1'b0 || mem_read !== 1'b0) $display("FAIL mid_reset_rdv got rdv=%b rd=%b exp 0/0", m0_readdatavalid, mem_read); else n_pass++;
        step();
        mem_readdatavalid = 1'b0;
        reset_n = 1'b1;
        step();
        m0_burstcount = 8'd1; m0_read = 1'b1;
        step();
        n_chk++; if (grant !== 2'b01 || mem_read !== 1'b1) $display("FAIL post_reset_grant got grant=%b rd=%b exp 01/1", grant, mem_read); else n_pass++;
        step();
        m0_read = 1'b0;
        mem_readdatavalid = 1'b1;
        #1;
        n_chk++; if (m0_readdatavalid !== 1'b1) $display("FAIL post_reset_beat got %b exp 1", m0_readdatavalid); else n_pass++;
        step();
        mem_readdatavalid = 1'b0;
        #1;
        n_chk++; if (grant !== 2'b00) $display("FAIL post_reset_idle got %b exp 00", grant); else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d checks", n_chk);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_only();
        test_write_only();
        test_stray_data();
        test_contention();
        test_urgency();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
